runway_scheduler: RTL and testbench

Single-runway scheduler for the airport control design. It buffers landing and takeoff requests in two small in-order queues and grants the runway to one aircraft at a time. It holds the runway busy for a fixed occupancy time per operation. It takes the weather/emergency unit's `severe_weather` and `emergency_landing_alert` outputs and blocks takeoffs while either is asserted; landings are always served.

---
 rtl/runway_scheduler.sv | 179 +++++++++++++++++
 tb/tb_runway_scheduler.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/runway_scheduler.sv
// runway_scheduler: single-runway arbiter. Landing and takeoff requests wait in
// two small FIFOs. One aircraft at a time holds the runway for a fixed number of
// cycles. Takeoffs are held back while the weather unit flags a hazard, and a
// waiting takeoff is forced through after MAX_CONSEC back-to-back landings.
module runway_scheduler #(
    parameter int DEPTH          = 4,
    parameter int LAND_CYCLES    = 6,
    parameter int TAKEOFF_CYCLES = 4,
    parameter int MAX_CONSEC     = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   land_req,
    input  logic [3:0]             land_id,
    input  logic                   takeoff_req,
    input  logic [3:0]             takeoff_id,
    input  logic                   severe_weather,
    input  logic                   emergency_landing_alert,
    output logic                   land_grant,
    output logic                   takeoff_grant,
    output logic [3:0]             grant_id,
    output logic                   runway_busy,
    output logic [$clog2(DEPTH):0] land_count,
    output logic [$clog2(DEPTH):0] takeoff_count,
    output logic [1:0]             reject,
    output logic [1:0]             sched_state
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (LAND_CYCLES > TAKEOFF_CYCLES) ? LAND_CYCLES : TAKEOFF_CYCLES;
    // Timer only ever holds occupancy-1.
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int KW   = $clog2(MAX_CONSEC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LAND = 2'b01,
        S_TKOF = 2'b10
    } state_t;

    // Queue storage
    logic [3:0]    land_mem_q [DEPTH];
    logic [3:0]    tk_mem_q   [DEPTH];
    logic [AW-1:0] land_wp_q, land_rp_q, tk_wp_q, tk_rp_q;
    logic [CW-1:0] land_cnt_q, land_cnt_d, tk_cnt_q, tk_cnt_d;

    // Scheduler state
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [KW-1:0] consec_q, consec_d;

    // Registered outputs
    logic          land_grant_q, land_grant_d;
    logic          tk_grant_q, tk_grant_d;
    logic [3:0]    grant_id_q, grant_id_d;
    logic          busy_q, busy_d;
    logic [1:0]    reject_q, reject_d;

    logic land_full, tk_full, land_push, tk_push;
    logic land_ne, tk_ne, tk_block;
    logic grant_land, grant_tk;

    // Fullness is judged on the pre-edge count, so a same-edge pop never
    // rescues a request aimed at a full queue.
    assign land_full = (land_cnt_q == CW'(DEPTH));
    assign tk_full   = (tk_cnt_q == CW'(DEPTH));
    assign land_push = land_req & ~land_full;
    assign tk_push   = takeoff_req & ~tk_full;
    assign land_ne   = (land_cnt_q != '0);
    assign tk_ne     = (tk_cnt_q != '0);
    assign tk_block  = severe_weather | emergency_landing_alert;

    assign land_cnt_d = land_cnt_q + CW'(land_push) - CW'(grant_land);
    assign tk_cnt_d   = tk_cnt_q + CW'(tk_push) - CW'(grant_tk);

    // FIFO storage and pointers; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                land_mem_q[i] <= '0;
                tk_mem_q[i]   <= '0;
            end
            land_wp_q  <= '0;
            land_rp_q  <= '0;
            tk_wp_q    <= '0;
            tk_rp_q    <= '0;
            land_cnt_q <= '0;
            tk_cnt_q   <= '0;
        end else begin
            if (land_push) begin
                land_mem_q[land_wp_q] <= land_id;
                land_wp_q             <= land_wp_q + AW'(1);
            end
            if (tk_push) begin
                tk_mem_q[tk_wp_q] <= takeoff_id;
                tk_wp_q           <= tk_wp_q + AW'(1);
            end
            if (grant_land) land_rp_q <= land_rp_q + AW'(1);
            if (grant_tk)   tk_rp_q   <= tk_rp_q + AW'(1);
            land_cnt_q <= land_cnt_d;
            tk_cnt_q   <= tk_cnt_d;
        end
    end

    // State register: FSM state, occupancy timer, landing streak, output regs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            consec_q     <= '0;
            land_grant_q <= 1'b0;
            tk_grant_q   <= 1'b0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
            reject_q     <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            consec_q     <= consec_d;
            land_grant_q <= land_grant_d;
            tk_grant_q   <= tk_grant_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            reject_q     <= reject_d;
        end
    end

    // Next state: grant decision when idle, otherwise count down the occupancy
    always_comb begin
        grant_land = 1'b0;
        grant_tk   = 1'b0;
        state_d    = state_q;
        timer_d    = timer_q;
        consec_d   = consec_q;
        case (state_q)
            S_IDLE: begin
                if (tk_ne && !tk_block && (consec_q == KW'(MAX_CONSEC))) grant_tk = 1'b1;
                else if (land_ne)                                         grant_land = 1'b1;
                else if (tk_ne && !tk_block)                              grant_tk = 1'b1;
                if (grant_land) begin
                    state_d = S_LAND;
                    timer_d = TW'(LAND_CYCLES - 1);
                end else if (grant_tk) begin
                    state_d = S_TKOF;
                    timer_d = TW'(TAKEOFF_CYCLES - 1);
                end
            end
            S_LAND, S_TKOF: begin
                if (timer_q == '0) state_d = S_IDLE;
                else               timer_d = timer_q - TW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // Streak only counts landings that made a takeoff wait.
        if (grant_tk || !tk_ne)                               consec_d = '0;
        else if (grant_land && consec_q != KW'(MAX_CONSEC))  consec_d = consec_q + KW'(1);
    end

    // Outputs: values the output registers take at this edge
    always_comb begin
        land_grant_d = grant_land;
        tk_grant_d   = grant_tk;
        grant_id_d   = '0;
        if (grant_land)    grant_id_d = land_mem_q[land_rp_q];
        else if (grant_tk) grant_id_d = tk_mem_q[tk_rp_q];
        busy_d   = (state_d != S_IDLE);
        reject_d = {takeoff_req & tk_full, land_req & land_full};
    end

    assign land_grant    = land_grant_q;
    assign takeoff_grant = tk_grant_q;
    assign grant_id      = grant_id_q;
    assign runway_busy   = busy_q;
    assign land_count    = land_cnt_q;
    assign takeoff_count = tk_cnt_q;
    assign reject        = reject_q;
    assign sched_state   = state_q;

endmodule

// File: tb/tb_runway_scheduler.sv
// Bench for runway_scheduler: directed scenarios plus random traffic, all
// compared each cycle against a queue-based reference model.
module tb_runway_scheduler;
    localparam int DEPTH = 4;
    localparam int LC    = 6;
    localparam int TC    = 4;
    localparam int MC    = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          land_req, takeoff_req, severe_weather, emergency_landing_alert;
    logic [3:0]    land_id, takeoff_id, grant_id;
    logic          land_grant, takeoff_grant, runway_busy;
    logic [CW-1:0] land_count, takeoff_count;
    logic [1:0]    reject, sched_state;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    runway_scheduler #(
        .DEPTH(DEPTH), .LAND_CYCLES(LC), .TAKEOFF_CYCLES(TC), .MAX_CONSEC(MC)
    ) dut (
        .CLK(CLK), .RST(RST),
        .land_req(land_req), .land_id(land_id),
        .takeoff_req(takeoff_req), .takeoff_id(takeoff_id),
        .severe_weather(severe_weather), .emergency_landing_alert(emergency_landing_alert),
        .land_grant(land_grant), .takeoff_grant(takeoff_grant), .grant_id(grant_id),
        .runway_busy(runway_busy), .land_count(land_count), .takeoff_count(takeoff_count),
        .reject(reject), .sched_state(sched_state)
    );

    typedef struct packed {
        logic          lg;
        logic          tg;
        logic [3:0]    gid;
        logic          busy;
        logic [CW-1:0] lc;
        logic [CW-1:0] tc;
        logic [1:0]    rej;
        logic [1:0]    st;
    } out_t;

    // Reference model: queues of IDs, the edge at which the runway frees up,
    // and the edge at which the next decision may happen.
    int   lq[$];
    int   tq[$];
    int   edge_no    = 0;
    int   next_dec   = 0;
    int   busy_until = 0;
    int   consec     = 0;
    bit   op_land    = 1'b0;
    out_t exp_o;

    function automatic out_t obs();
        out_t o;
        o.lg   = land_grant;
        o.tg   = takeoff_grant;
        o.gid  = (land_grant | takeoff_grant) ? grant_id : 4'd0;
        o.busy = runway_busy;
        o.lc   = land_count;
        o.tc   = takeoff_count;
        o.rej  = reject;
        o.st   = sched_state;
        return o;
    endfunction

    task automatic model_reset();
        lq.delete();
        tq.delete();
        consec     = 0;
        next_dec   = edge_no;
        busy_until = edge_no;
        op_land    = 1'b0;
    endtask

    task automatic model_edge(input int lr, input int lid, input int tr, input int tid, input int blk);
        bit lfull = (lq.size() >= DEPTH);
        bit tfull = (tq.size() >= DEPTH);
        bit tk_ne = (tq.size() > 0);
        bit gl = 1'b0;
        bit gt = 1'b0;
        int id = 0;
        exp_o = '0;
        if (edge_no >= next_dec) begin
            if (tq.size() > 0 && blk == 0 && consec == MC) gt = 1'b1;
            else if (lq.size() > 0)                          gl = 1'b1;
            else if (tq.size() > 0 && blk == 0)              gt = 1'b1;
        end
        if (gl) begin
            id = lq.pop_front(); op_land = 1'b1;
            busy_until = edge_no + LC; next_dec = busy_until + 1;
        end
        if (gt) begin
            id = tq.pop_front(); op_land = 1'b0;
            busy_until = edge_no + TC; next_dec = busy_until + 1;
        end
        if (gt || !tk_ne)          consec = 0;
        else if (gl && consec < MC) consec++;
        if (lr != 0) begin
            if (!lfull) lq.push_back(lid);
            else        exp_o.rej[0] = 1'b1;
        end
        if (tr != 0) begin
            if (!tfull) tq.push_back(tid);
            else        exp_o.rej[1] = 1'b1;
        end
        exp_o.lg   = gl;
        exp_o.tg   = gt;
        exp_o.gid  = 4'(id);
        exp_o.busy = (edge_no < busy_until);
        exp_o.st   = exp_o.busy ? (op_land ? 2'b01 : 2'b10) : 2'b00;
        exp_o.lc   = CW'(lq.size());
        exp_o.tc   = CW'(tq.size());
        edge_no++;
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input int lr, input int lid, input int tr, input int tid, input int sw, input int ea);
        land_req                = (lr != 0);
        land_id                 = 4'(lid);
        takeoff_req             = (tr != 0);
        takeoff_id              = 4'(tid);
        severe_weather          = (sw != 0);
        emergency_landing_alert = (ea != 0);
        model_edge(lr, lid, tr, tid, sw | ea);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        land_req = 1'b1; land_id = 4'd3; takeoff_req = 1'b1; takeoff_id = 4'd4;
        severe_weather = 1'b0; emergency_landing_alert = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        tests++;
        if (obs() !== '0) begin
            fails++; $display("FAIL reset_outputs got %h exp 0", obs());
        end
        tests++;
        if (grant_id !== 4'd0) begin
            fails++; $display("FAIL reset_grant_id got %0d exp 0", grant_id);
        end
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            tests++;
            if (obs() !== exp_o) begin
                fails++; $display("FAIL reset_idle cyc %0d got %h exp %h", i, obs(), exp_o);
            end
        end
    endtask

    task automatic test_single_landing();
        int busy_cyc = 0;
        int grants   = 0;
        bit first_ok = 1'b0;
        step(1, 5, 0, 0, 0, 0);
        tests++;
        if (obs() !== exp_o) begin
            fails++; $display("FAIL single_enq got %h exp %h", obs(), exp_o);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 0);
            tests++;
            if (obs() !== exp_o) begin
                fails++; $display("FAIL single_landing cyc %0d got %h exp %h", i, obs(), exp_o);
            end
            if (runway_busy === 1'b1) busy_cyc++;
            if (land_grant === 1'b1) begin
                grants++;
                if (i == 0 && grant_id === 4'd5 && sched_state === 2'b01) first_ok = 1'b1;
            end
        end
        tests++;
        if (busy_cyc != LC) begin
            fails++; $display("FAIL single_busy_len got %0d exp %0d", busy_cyc, LC);
        end
        tests++;
        if (grants != 1 || !first_ok) begin
            fails++; $display("FAIL single_grant got grants=%0d first_ok=%0d exp 1/1", grants, first_ok);
        end
    endtask

    task automatic test_priority();
        int exp_id[6]   = '{1, 2, 3, 9, 4, 5};
        int exp_land[6] = '{1, 1, 1, 0, 1, 1};
        int gid[$];
        int gedge[$];
        int gland[$];
        for (int i = 0; i < 50; i++) begin
            if (i < 5) step(1, i + 1, (i == 0) ? 1 : 0, 9, 0, 0);
            else       step(0, 0, 0, 0, 0, 0);
            tests++;
            if (obs() !== exp_o) begin
                fails++; $display("FAIL priority cyc %0d got %h exp %h", i, obs(), exp_o);
            end
            if (land_grant === 1'b1 || takeoff_grant === 1'b1) begin
                gid.push_back(int'(grant_id));
                gedge.push_back(i);
                gland.push_back(int'(land_grant));
            end
        end
        tests++;
        if (gid.size() != 6) begin
            fails++; $display("FAIL priority_count got %0d exp 6", gid.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                tests++;
                if (gid[k] != exp_id[k] || gland[k] != exp_land[k]) begin
                    fails++;
                    $display("FAIL priority_order idx %0d got id=%0d land=%0d exp id=%0d land=%0d",
                             k, gid[k], gland[k], exp_id[k], exp_land[k]);
                end
                if (k > 0) begin
                    tests++;
                    if (gedge[k] - gedge[k-1] != ((gland[k-1] != 0) ? LC + 1 : TC + 1)) begin
                        fails++;
                        $display("FAIL priority_spacing idx %0d got %0d exp %0d", k,
                                 gedge[k] - gedge[k-1], (gland[k-1] != 0) ? LC + 1 : TC + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_weather();
        for (int w = 0; w < 2; w++) begin
            int blocked = 0;
            step(0, 0, 1, 7, (w == 0) ? 1 : 0, (w == 1) ? 1 : 0);
            for (int i = 0; i < 8; i++) begin
                step(0, 0, 0, 0, (w == 0) ? 1 : 0, (w == 1) ? 1 : 0);
                tests++;
                if (obs() !== exp_o) begin
                    fails++; $display("FAIL weather%0d_hold cyc %0d got %h exp %h", w, i, obs(), exp_o);
                end
                if (takeoff_grant === 1'b1) blocked++;
            end
            tests++;
            if (blocked != 0 || takeoff_count !== CW'(1)) begin
                fails++; $display("FAIL weather%0d_block got grants=%0d count=%0d exp 0/1", w, blocked, takeoff_count);
            end
            step(0, 0, 0, 0, 0, 0);
            tests++;
            if (takeoff_grant !== 1'b1 || grant_id !== 4'd7) begin
                fails++; $display("FAIL weather%0d_release got tg=%b id=%0d exp 1/7", w, takeoff_grant, grant_id);
            end
            for (int i = 0; i < 6; i++) begin
                step(0, 0, 0, 0, 0, 0);
                tests++;
                if (obs() !== exp_o) begin
                    fails++; $display("FAIL weather%0d_drain cyc %0d got %h exp %h", w, i, obs(), exp_o);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int max_lc = 0;
        int rej0   = 0;
        int lgr    = 0;
        bit saw14  = 1'b0;
        step(0, 0, 1, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if (obs() !== exp_o) begin
            fails++; $display("FAIL overflow_tk got %h exp %h", obs(), exp_o);
        end
        for (int i = 0; i < 45; i++) begin
            if (i < 5) step(1, 10 + i, 0, 0, 0, 0);
            else       step(0, 0, 0, 0, 0, 0);
            tests++;
            if (obs() !== exp_o) begin
                fails++; $display("FAIL overflow cyc %0d got %h exp %h", i, obs(), exp_o);
            end
            if (int'(land_count) > max_lc) max_lc = int'(land_count);
            if (reject[0] === 1'b1) rej0++;
            if (land_grant === 1'b1) begin
                lgr++;
                if (grant_id === 4'd14) saw14 = 1'b1;
            end
        end
        tests++;
        if (max_lc != DEPTH || rej0 != 1 || lgr != 4 || saw14) begin
            fails++;
            $display("FAIL overflow_summary got max=%0d rej=%0d grants=%0d id14=%0d exp 4/1/4/0",
                     max_lc, rej0, lgr, saw14);
        end
    endtask

    task automatic test_weather_mid();
        int busy_cyc = 0;
        int tg_wx    = 0;
        step(0, 0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if (takeoff_grant !== 1'b1 || grant_id !== 4'd2) begin
            fails++; $display("FAIL wxmid_grant got tg=%b id=%0d exp 1/2", takeoff_grant, grant_id);
        end
        if (runway_busy === 1'b1) busy_cyc++;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, (i == 0) ? 1 : 0, 6, 1, 0);
            tests++;
            if (obs() !== exp_o) begin
                fails++; $display("FAIL wxmid cyc %0d got %h exp %h", i, obs(), exp_o);
            end
            if (runway_busy === 1'b1) busy_cyc++;
            if (takeoff_grant === 1'b1) tg_wx++;
        end
        tests++;
        if (busy_cyc != TC || tg_wx != 0) begin
            fails++; $display("FAIL wxmid_summary got busy=%0d tg=%0d exp %0d/0", busy_cyc, tg_wx, TC);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0, 0);
            tests++;
            if (obs() !== exp_o) begin
                fails++; $display("FAIL wxmid_release cyc %0d got %h exp %h", i, obs(), exp_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        int gr = 0;
        step(1, 1, 1, 8, 1, 0);
        step(1, 2, 1, 9, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        tests++;
        if (obs() !== exp_o || sched_state !== 2'b01) begin
            fails++; $display("FAIL rstmid_pre got %h exp %h", obs(), exp_o);
        end
        #2;
        RST = 1'b1;
        #1;
        tests++;
        if (obs() !== '0 || grant_id !== 4'd0) begin
            fails++; $display("FAIL rstmid_async got %h id=%0d exp 0", obs(), grant_id);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0, 0, 0);
            tests++;
            if (obs() !== exp_o) begin
                fails++; $display("FAIL rstmid_after cyc %0d got %h exp %h", i, obs(), exp_o);
            end
            if (land_grant === 1'b1 || takeoff_grant === 1'b1) gr++;
        end
        tests++;
        if (gr != 0) begin
            fails++; $display("FAIL rstmid_nogrant got %0d exp 0", gr);
        end
        step(0, 0, 1, 4, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if (takeoff_grant !== 1'b1 || grant_id !== 4'd4 || obs() !== exp_o) begin
            fails++; $display("FAIL rstmid_new got tg=%b id=%0d exp 1/4", takeoff_grant, grant_id);
        end
        repeat (6) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int lr = ($urandom_range(0, 3) == 0) ? 1 : 0;
            int tr = ($urandom_range(0, 3) == 0) ? 1 : 0;
            int sw = ($urandom_range(0, 5) == 0) ? 1 : 0;
            int ea = ($urandom_range(0, 7) == 0) ? 1 : 0;
            step(lr, int'($urandom_range(0, 15)), tr, int'($urandom_range(0, 15)), sw, ea);
            tests++;
            if (obs() !== exp_o) begin
                fails++; $display("FAIL random cyc %0d got %h exp %h", i, obs(), exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_landing();
        test_priority();
        test_weather();
        test_overflow();
        test_weather_mid();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
